main_mem_burst: RTL and testbench

Block-transfer main memory sitting directly downstream of the cache: it accepts one block request at a time from the cache's miss/write-back logic and serves it after a fixed access latency as a 4-beat, one-word-per-cycle burst. It holds 256 32-bit words (1 KiB, 10-bit byte address) and signals completion with a one-cycle `Done` pulse, replacing the zero-latency combinational memory model in the cache lab top.

---
 rtl/main_mem_pkg.sv | 26 ++
 rtl/main_mem_array.sv | 28 ++
 rtl/main_mem_burst.sv | 125 ++++++++++++
 tb/tb_main_mem_burst.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// rtl/main_mem_pkg.sv - shared types, sizes and address fields for the burst main memory
package main_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        XFER   = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 4;
    localparam int MEM_WORDS   = 256;
    localparam int MEM_AW      = 8;

    localparam int BLOCK_HI = 9;
    localparam int BLOCK_LO = 4;
    localparam int WORD_HI  = 3;
    localparam int WORD_LO  = 2;

    function automatic logic [MEM_AW-1:0] word_addr(input logic [BLOCK_HI-BLOCK_LO:0] blk,
                                                    input logic [WORD_HI-WORD_LO:0] wrd);
        return {blk, wrd};
    endfunction

endpackage

// File: rtl/main_mem_array.sv
// rtl/main_mem_array.sv - 256x32 storage, combinational read, synchronous write
module main_mem_array import main_mem_pkg::*; (
    input  logic              clock,
    input  logic              we,
    input  logic [MEM_AW-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [MEM_AW-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] words [MEM_WORDS];

    // Each word powers up holding its own index; contents are never reset.
    for (genvar i = 0; i < MEM_WORDS; i++) begin : g_word
        logic [WORD_W-1:0] q = WORD_W'(i);

        always_ff @(posedge clock) begin
            if (we && waddr == MEM_AW'(i)) begin
                q <= wdata;
            end
        end

        assign words[i] = q;
    end

    assign rdata = words[raddr];

endmodule

// File: rtl/main_mem_burst.sv
// rtl/main_mem_burst.sv - fixed-latency 4-beat block memory; MAIN_MEM_CWF_EN enables critical-word-first
module main_mem_burst import main_mem_pkg::*; #(
    parameter int LATENCY     = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cache_req,
    input  logic              cache_rOw,
    input  logic [9:0]        cache_address,
    input  logic [WORD_W-1:0] cache_writeData,
    output logic [WORD_W-1:0] main_readData,
    output logic              main_valid,
    output logic              main_wready,
    output logic [1:0]        main_beat,
    output logic              main_busy,
    output logic              Done
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("main_mem_burst: LATENCY must be within 1..15");
    end
    if (BLOCK_WORDS != main_mem_pkg::BLOCK_WORDS) begin : g_bad_block
        $error("main_mem_burst: BLOCK_WORDS must be 4");
    end

    mem_state_t  state;
    logic        rw_q;
    logic [5:0]  blk_q;
    logic [1:0]  first_word_q;
    logic [3:0]  lat_q;
    logic [1:0]  beat_cnt;
    logic [1:0]  start_word;
    logic [1:0]  fetch_word;
    logic [WORD_W-1:0] rd_data;
    logic        unused_addr;

`ifdef MAIN_MEM_CWF_EN
    assign start_word  = cache_address[WORD_HI:WORD_LO];
    assign unused_addr = ^cache_address[1:0];
`else
    assign start_word  = 2'd0;
    assign unused_addr = ^{cache_address[WORD_HI:WORD_LO], cache_address[1:0]};
`endif

    // Word whose data must be registered at the coming edge for the next beat.
    assign fetch_word = (state == ACCESS) ? first_word_q : main_beat + 2'd1;

    main_mem_array u_array (
        .clock (clock),
        .we    (main_wready),
        .waddr (word_addr(blk_q, main_beat)),
        .wdata (cache_writeData),
        .raddr (word_addr(blk_q, fetch_word)),
        .rdata (rd_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rw_q          <= 1'b0;
            blk_q         <= '0;
            first_word_q  <= '0;
            lat_q         <= '0;
            beat_cnt      <= '0;
            main_readData <= '0;
            main_valid    <= 1'b0;
            main_wready   <= 1'b0;
            main_beat     <= '0;
            main_busy     <= 1'b0;
            Done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cache_req) begin
                        rw_q         <= cache_rOw;
                        blk_q        <= cache_address[BLOCK_HI:BLOCK_LO];
                        first_word_q <= start_word;
                        lat_q        <= 4'(LATENCY - 1);
                        main_busy    <= 1'b1;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_q == 4'd0) begin
                        state     <= XFER;
                        beat_cnt  <= 2'd0;
                        main_beat <= first_word_q;
                        if (rw_q) begin
                            main_wready <= 1'b1;
                        end else begin
                            main_valid    <= 1'b1;
                            main_readData <= rd_data;
                        end
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                XFER: begin
                    if (beat_cnt == 2'd3) begin
                        main_valid    <= 1'b0;
                        main_wready   <= 1'b0;
                        main_readData <= '0;
                        main_beat     <= '0;
                        Done          <= 1'b1;
                        state         <= DONE;
                    end else begin
                        beat_cnt  <= beat_cnt + 2'd1;
                        main_beat <= fetch_word;
                        if (!rw_q) begin
                            main_readData <= rd_data;
                        end
                    end
                end
                DONE: begin
                    Done      <= 1'b0;
                    main_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_burst.sv
// tb/tb_main_mem_burst.sv - directed self-checking bench for main_mem_burst
module tb_main_mem_burst;

    localparam int L = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cache_req = 1'b0;
    logic        cache_rOw = 1'b0;
    logic [9:0]  cache_address = '0;
    logic [31:0] cache_writeData = '0;
    logic [31:0] main_readData;
    logic        main_valid;
    logic        main_wready;
    logic [1:0]  main_beat;
    logic        main_busy;
    logic        Done;

    int n_total = 0;
    int n_pass  = 0;

    main_mem_burst #(.LATENCY(L), .BLOCK_WORDS(4)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .cache_req       (cache_req),
        .cache_rOw       (cache_rOw),
        .cache_address   (cache_address),
        .cache_writeData (cache_writeData),
        .main_readData   (main_readData),
        .main_valid      (main_valid),
        .main_wready     (main_wready),
        .main_beat       (main_beat),
        .main_busy       (main_busy),
        .Done            (Done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_outs(input string tag, input logic busy, input logic valid,
                            input logic wready, input logic [1:0] beat,
                            input logic [31:0] data, input logic done);
        chk({tag, ".busy"},   32'(main_busy),   32'(busy));
        chk({tag, ".valid"},  32'(main_valid),  32'(valid));
        chk({tag, ".wready"}, 32'(main_wready), 32'(wready));
        chk({tag, ".beat"},   32'(main_beat),   32'(beat));
        chk({tag, ".data"},   main_readData,    data);
        chk({tag, ".done"},   32'(Done),        32'(done));
    endtask

    // Called mid-cycle; edge 0 is the next rising edge. Returns mid-cycle L+6.
    task automatic run_burst(input string tag, input logic rw, input logic [9:0] addr,
                             input logic hold, input logic [1:0] words [4],
                             input logic [31:0] data [4]);
        int k;
        logic in_beat;
        cache_req     = 1'b1;
        cache_rOw     = rw;
        cache_address = addr;
        @(posedge clock);
        for (int c = 1; c <= L + 6; c++) begin
            @(negedge clock);
            if (!hold) cache_req = 1'b0;
            k = c - L - 1;
            in_beat = (k >= 0) && (k <= 3);
            chk_outs($sformatf("%s.c%0d", tag, c), c <= L + 5,
                     in_beat && !rw, in_beat && rw,
                     in_beat ? words[k] : 2'd0,
                     (in_beat && !rw) ? data[k] : 32'd0,
                     c == L + 5);
            if (in_beat && rw) cache_writeData = data[k];
        end
    endtask

    logic [1:0]  seq_w [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0]  cwf_w [4];
    logic [31:0] d [4];

    initial begin
        // Reset state
        #12;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk_outs("idle", 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);

        // Sequential read of block 2: words 8..11
        d = '{32'd8, 32'd9, 32'd10, 32'd11};
        run_burst("rd024", 1'b0, 10'h024, 1'b0, seq_w, d);

        // Write block 16 then read it back, neighbours untouched
        d = '{32'hA5A5_00A0, 32'hA5A5_00A1, 32'hA5A5_00A2, 32'hA5A5_00A3};
        run_burst("wr100", 1'b1, 10'h100, 1'b0, seq_w, d);
        run_burst("rb100", 1'b0, 10'h100, 1'b0, seq_w, d);
        d = '{32'd60, 32'd61, 32'd62, 32'd63};
        run_burst("rd0fc", 1'b0, 10'h0FC, 1'b0, seq_w, d);
        d = '{32'd68, 32'd69, 32'd70, 32'd71};
        run_burst("rd110", 1'b0, 10'h110, 1'b0, seq_w, d);

        // Start word 3 of block 3
`ifdef MAIN_MEM_CWF_EN
        cwf_w = '{2'd3, 2'd0, 2'd1, 2'd2};
        d = '{32'd15, 32'd12, 32'd13, 32'd14};
`else
        cwf_w = seq_w;
        d = '{32'd12, 32'd13, 32'd14, 32'd15};
`endif
        run_burst("rd03c", 1'b0, 10'h03C, 1'b0, cwf_w, d);

        // Request held high: one burst, idle in cycle 10, second accepted at its end
        d = '{32'd4, 32'd5, 32'd6, 32'd7};
        run_burst("hold", 1'b0, 10'h010, 1'b1, seq_w, d);
        @(negedge clock);
        cache_req = 1'b0;
        chk("hold.c11.busy", 32'(main_busy), 32'd1);
        repeat (L + 6) @(negedge clock);
        chk("hold.after.busy", 32'(main_busy), 32'd0);

        // Reset during the second write beat of block 32
        cache_req = 1'b1;
        cache_rOw = 1'b1;
        cache_address = 10'h200;
        @(posedge clock);
        for (int c = 1; c <= L + 2; c++) begin
            @(negedge clock);
            cache_req = 1'b0;
            if (c == L + 1) cache_writeData = 32'hBEEF_0000;
            if (c == L + 2) cache_writeData = 32'hBEEF_0001;
        end
        chk("rst.beat1.wready", 32'(main_wready), 32'd1);
        chk("rst.beat1.beat", 32'(main_beat), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk_outs("rst.async", 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clock);
        chk("rst.nodone", 32'(Done), 32'd0);
        reset_n = 1'b1;
        repeat (L + 6) @(negedge clock);
        chk_outs("rst.quiet", 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
        d = '{32'hBEEF_0000, 32'd129, 32'd130, 32'd131};
        run_burst("rd200", 1'b0, 10'h200, 1'b0, seq_w, d);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
